// File: rtl/pipelined_cpu.sv
// ---------------------------------------------------------------------------
// pipelined_cpu -- 5-stage (IF/ID/EX/MEM/WB) in-order RV32 integer core.
//
// Executes add, sub, and, or, xor, sll, mul, addi, srai, lw, sw and beq.
// Every other encoding, including the all-zero word, executes as a NOP.
// Load-use hazards insert one stall cycle. Other RAW hazards are forwarded
// into EX. beq resolves in ID; a taken branch flushes the single slot behind it.
//
// Ports:
//   clk_i          in   1   clock; all state changes on the rising edge
//   start_i        in   1   asynchronous active-low reset (1 = run)
//   stall_count_o  out  32  load-use stall cycles, saturating (PERF_COUNTERS_EN only)
//   flush_count_o  out  32  taken beq count, saturating       (PERF_COUNTERS_EN only)
//
// Backdoor state, preloaded and inspected hierarchically:
//   instruction_memory.memory, data_memory.memory, register.register
//
// Optional feature macro: PERF_COUNTERS_EN
// ---------------------------------------------------------------------------

// Instruction memory. The write port exists only so the array has a driver.
// The core ties it off; contents come from the backdoor.
module cpu_imem #(
  parameter int WORDS = 256,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] memory [WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) memory[waddr_i] <= wdata_i;
  end

  assign rdata_o = memory[raddr_i];
endmodule

// Byte-wide data memory. Accesses are little-endian 32-bit words.
// addr_i is always word aligned. Reads are combinational.
module cpu_dmem #(
  parameter int BYTES = 32,
  parameter int AW    = 5
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [7:0] memory [BYTES];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      memory[{addr_i[AW-1:2], 2'd0}] <= wdata_i[7:0];
      memory[{addr_i[AW-1:2], 2'd1}] <= wdata_i[15:8];
      memory[{addr_i[AW-1:2], 2'd2}] <= wdata_i[23:16];
      memory[{addr_i[AW-1:2], 2'd3}] <= wdata_i[31:24];
    end
  end

  assign rdata_o = {memory[{addr_i[AW-1:2], 2'd3}], memory[{addr_i[AW-1:2], 2'd2}],
                    memory[{addr_i[AW-1:2], 2'd1}], memory[{addr_i[AW-1:2], 2'd0}]};
endmodule

// Register file. x0 is hardwired to zero. A WB write is visible to an ID read
// in the same cycle.
module cpu_regfile (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);
  logic [31:0] register [32];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) register[i] <= '0;
    end else if (we_i && waddr_i != 5'd0) begin
      register[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = register[raddr1_i];
    rdata2_o = register[raddr2_i];
    if (we_i && waddr_i == raddr1_i) rdata1_o = wdata_i;
    if (we_i && waddr_i == raddr2_i) rdata2_o = wdata_i;
    if (raddr1_i == 5'd0) rdata1_o = '0;
    if (raddr2_i == 5'd0) rdata2_o = '0;
  end
endmodule

module pipelined_cpu #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_BYTES = 32
) (
  input  logic        clk_i,
  input  logic        start_i
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0] stall_count_o,
  output logic [31:0] flush_count_o
`endif
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_BYTES);

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_MUL, ALU_SRA
  } alu_op_e;

  // An all-zero pipeline register is a bubble: it writes neither the
  // register file nor memory.
  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        use_imm;
    alu_op_e     alu_op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
  } idex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] store_data;
  } exmem_t;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] result;
  } memwb_t;

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  idex_t       idex_q, idex_d;
  exmem_t      exmem_q, exmem_d;
  memwb_t      memwb_q, memwb_d;

  // ---------------- IF ----------------
  logic [31:0] imem_rdata;

  cpu_imem #(.WORDS(IMEM_WORDS), .AW(IAW)) instruction_memory (
    .clk_i   (clk_i),
    .we_i    (1'b0),
    .waddr_i ({IAW{1'b0}}),
    .wdata_i (32'd0),
    .raddr_i (pc_q[IAW+1:2]),
    .rdata_o (imem_rdata)
  );

  // ---------------- ID ----------------
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, rs1_val, rs2_val;
  logic        id_reg_write, id_mem_read, id_mem_write, id_use_imm;
  logic        id_uses_rs1, id_uses_rs2, id_is_beq;
  alu_op_e     id_alu_op;
  logic [31:0] id_imm;
  logic        load_use, branch_taken;

  assign opcode = ifid_instr_q[6:0];
  assign rd     = ifid_instr_q[11:7];
  assign funct3 = ifid_instr_q[14:12];
  assign rs1    = ifid_instr_q[19:15];
  assign rs2    = ifid_instr_q[24:20];
  assign funct7 = ifid_instr_q[31:25];
  assign imm_i  = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:20]};
  assign imm_s  = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:25], ifid_instr_q[11:7]};
  assign imm_b  = {{19{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[7],
                   ifid_instr_q[30:25], ifid_instr_q[11:8], 1'b0};

  cpu_regfile register (
    .clk_i    (clk_i),
    .rst_ni   (start_i),
    .we_i     (memwb_q.reg_write),
    .waddr_i  (memwb_q.rd),
    .wdata_i  (memwb_q.result),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rs1_val),
    .rdata2_o (rs2_val)
  );

  always_comb begin
    id_reg_write = 1'b0;
    id_mem_read  = 1'b0;
    id_mem_write = 1'b0;
    id_use_imm   = 1'b0;
    id_uses_rs1  = 1'b0;
    id_uses_rs2  = 1'b0;
    id_is_beq    = 1'b0;
    id_alu_op    = ALU_ADD;
    id_imm       = imm_i;
    case (opcode)
      7'b0110011: begin
        id_reg_write = 1'b1;
        id_uses_rs1  = 1'b1;
        id_uses_rs2  = 1'b1;
        case ({funct7, funct3})
          10'h000: id_alu_op = ALU_ADD;
          10'h100: id_alu_op = ALU_SUB;
          10'h007: id_alu_op = ALU_AND;
          10'h006: id_alu_op = ALU_OR;
          10'h004: id_alu_op = ALU_XOR;
          10'h001: id_alu_op = ALU_SLL;
          10'h008: id_alu_op = ALU_MUL;
          default: begin
            id_reg_write = 1'b0;
            id_uses_rs1  = 1'b0;
            id_uses_rs2  = 1'b0;
          end
        endcase
      end
      7'b0010011: begin
        if (funct3 == 3'b000 || (funct3 == 3'b101 && funct7 == 7'b0100000)) begin
          id_reg_write = 1'b1;
          id_uses_rs1  = 1'b1;
          id_use_imm   = 1'b1;
          id_alu_op    = (funct3 == 3'b101) ? ALU_SRA : ALU_ADD;
        end
      end
      7'b0000011: begin
        if (funct3 == 3'b010) begin
          id_reg_write = 1'b1;
          id_mem_read  = 1'b1;
          id_uses_rs1  = 1'b1;
          id_use_imm   = 1'b1;
        end
      end
      7'b0100011: begin
        if (funct3 == 3'b010) begin
          id_mem_write = 1'b1;
          id_uses_rs1  = 1'b1;
          id_uses_rs2  = 1'b1;
          id_use_imm   = 1'b1;
          id_imm       = imm_s;
        end
      end
      7'b1100011: begin
        if (funct3 == 3'b000) begin
          id_is_beq   = 1'b1;
          id_uses_rs1 = 1'b1;
          id_uses_rs2 = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // The load result is available only after MEM. A dependent instruction in ID
  // must therefore wait one cycle. A stall suppresses a branch in the same
  // cycle; the branch is evaluated again on the next cycle.
  assign load_use = idex_q.mem_read && (idex_q.rd != 5'd0) &&
                    ((id_uses_rs1 && idex_q.rd == rs1) ||
                     (id_uses_rs2 && idex_q.rd == rs2));
  assign branch_taken = id_is_beq && (rs1_val == rs2_val) && !load_use;

  always_comb begin
    pc_d         = pc_q + 32'd4;
    ifid_instr_d = imem_rdata;
    ifid_pc_d    = pc_q;
    idex_d = '{reg_write: id_reg_write, mem_read: id_mem_read, mem_write: id_mem_write,
               use_imm: id_use_imm, alu_op: id_alu_op, rd: rd, rs1: rs1, rs2: rs2,
               rs1_val: rs1_val, rs2_val: rs2_val, imm: id_imm};
    if (load_use) begin
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      idex_d       = '0;
    end else if (branch_taken) begin
      pc_d         = ifid_pc_q + imm_b;
      ifid_instr_d = '0;
      ifid_pc_d    = '0;
    end
  end

  // ---------------- EX ----------------
  logic [31:0] fwd_a, fwd_b, alu_b, alu_res;

  always_comb begin
    fwd_a = idex_q.rs1_val;
    fwd_b = idex_q.rs2_val;
    if (memwb_q.reg_write && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs1) fwd_a = memwb_q.result;
    if (memwb_q.reg_write && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs2) fwd_b = memwb_q.result;
    // The younger producer in EX/MEM overrides MEM/WB.
    if (exmem_q.reg_write && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs1) fwd_a = exmem_q.alu;
    if (exmem_q.reg_write && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs2) fwd_b = exmem_q.alu;
    alu_b = idex_q.use_imm ? idex_q.imm : fwd_b;
    case (idex_q.alu_op)
      ALU_ADD: alu_res = fwd_a + alu_b;
      ALU_SUB: alu_res = fwd_a - alu_b;
      ALU_AND: alu_res = fwd_a & alu_b;
      ALU_OR:  alu_res = fwd_a | alu_b;
      ALU_XOR: alu_res = fwd_a ^ alu_b;
      ALU_SLL: alu_res = fwd_a << alu_b[4:0];
      ALU_MUL: alu_res = fwd_a * alu_b;
      default: alu_res = $signed(fwd_a) >>> alu_b[4:0];
    endcase
    exmem_d = '{reg_write: idex_q.reg_write, mem_read: idex_q.mem_read,
                mem_write: idex_q.mem_write, rd: idex_q.rd, alu: alu_res, store_data: fwd_b};
  end

  // ---------------- MEM ----------------
  logic [31:0] dmem_rdata;

  cpu_dmem #(.BYTES(DMEM_BYTES), .AW(DAW)) data_memory (
    .clk_i   (clk_i),
    .we_i    (exmem_q.mem_write),
    .addr_i  ({exmem_q.alu[DAW-1:2], 2'b00}),
    .wdata_i (exmem_q.store_data),
    .rdata_o (dmem_rdata)
  );

  always_comb begin
    memwb_d = '{reg_write: exmem_q.reg_write, rd: exmem_q.rd,
                result: exmem_q.mem_read ? dmem_rdata : exmem_q.alu};
  end

  // ---------------- pipeline state ----------------
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      pc_q         <= '0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      idex_q       <= '0;
      exmem_q      <= '0;
      memwb_q      <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      idex_q       <= idex_d;
      exmem_q      <= exmem_d;
      memwb_q      <= memwb_d;
    end
  end

`ifdef PERF_COUNTERS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (load_use && stall_cnt_q != 32'hFFFF_FFFF)     stall_cnt_d = stall_cnt_q + 32'd1;
    if (branch_taken && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count_o = stall_cnt_q;
  assign flush_count_o = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipelined_cpu.sv
// ---------------------------------------------------------------------------
// tb_pipelined_cpu -- self-checking bench for pipelined_cpu.
// Programs are loaded through the instruction-memory backdoor. Expected
// architectural state is queued when a program is set up, each entry tagged
// with the clock edge (counted from reset release) at which it must hold.
// Cycle 0 means at the end of the run. Entries are popped and compared as
// the run reaches them. Connects the perf counters when PERF_COUNTERS_EN is
// defined.
// ---------------------------------------------------------------------------
module tb_pipelined_cpu;
  logic clk_i   = 1'b0;
  logic start_i = 1'b1;

  always #5 clk_i = ~clk_i;

`ifdef PERF_COUNTERS_EN
  logic [31:0] stall_count_o, flush_count_o;
`endif

  pipelined_cpu #(.IMEM_WORDS(256), .DMEM_BYTES(32)) dut (
    .clk_i   (clk_i),
    .start_i (start_i)
`ifdef PERF_COUNTERS_EN
    ,
    .stall_count_o (stall_count_o),
    .flush_count_o (flush_count_o)
`endif
  );

  int tests_run    = 0;
  int tests_failed = 0;

  typedef enum int {K_REG, K_DMEM, K_STALL, K_FLUSH} kind_e;
  typedef struct {
    int          cyc;
    kind_e       kind;
    int          idx;
    logic [31:0] exp;
    string       tag;
  } exp_t;
  exp_t sb_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %h", tag, got);
    end
  endtask

  task automatic expect_at(input int cyc, input kind_e kind, input int idx,
                           input logic [31:0] exp, input string tag);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.idx = idx; e.exp = exp; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic expect_perf(input logic [31:0] stalls, input logic [31:0] flushes, input string tag);
`ifdef PERF_COUNTERS_EN
    expect_at(0, K_STALL, 0, stalls, {tag, " stall_count"});
    expect_at(0, K_FLUSH, 0, flushes, {tag, " flush_count"});
`else
    if (stalls != flushes) begin end
    if (tag.len() < 0) begin end
`endif
  endtask

  function automatic logic [31:0] observe(input kind_e kind, input int idx);
    logic [4:0] a;
    a = idx[4:0];
    case (kind)
      K_REG:   return dut.register.register[a];
      K_DMEM:  return {24'd0, dut.data_memory.memory[a]};
`ifdef PERF_COUNTERS_EN
      K_STALL: return stall_count_o;
      K_FLUSH: return flush_count_o;
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Instruction encoders
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction
  function automatic logic [31:0] enc_sw(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b010, rd, 7'b0000011);
  endfunction
  function automatic logic [31:0] enc_beq(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic put(input int addr, input logic [31:0] w);
    dut.instruction_memory.memory[addr] = w;
  endtask

  // Hold the core in reset and clear both memories.
  task automatic prep();
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 256; i++) dut.instruction_memory.memory[i] = 32'd0;
    for (int i = 0; i < 32; i++) dut.data_memory.memory[i] = 8'd0;
    @(negedge clk_i);
  endtask

  // Cycle c counts rising edges after reset release.
  task automatic run_program(input int cycles, input bit do_release);
    exp_t e;
    if (do_release) begin
      @(negedge clk_i);
      start_i = 1'b1;
    end
    for (int c = 1; c <= cycles; c++) begin
      @(posedge clk_i);
      #1;
      while (sb_q.size() > 0 && sb_q[0].cyc == c) begin
        e = sb_q.pop_front();
        check_val(e.tag, observe(e.kind, e.idx), e.exp);
      end
    end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.kind, e.idx), e.exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 start_i = 1'b0;
    #10;
    check_val("reset pc", dut.pc_q, 32'd0);
    check_val("reset ifid_instr", dut.ifid_instr_q, 32'd0);
    check_val("reset x5", dut.register.register[5], 32'd0);

    // Back-to-back forwarding with no stalls: x3 retires at edge 7
    prep();
    put(0, addi(1, 0, 12'd5));
    put(1, addi(2, 1, 12'd3));
    put(2, enc_r(7'h00, 1, 2, 3'b000, 3));
    expect_at(6, K_REG, 3, 32'd0,  "fwd x3 before retire");
    expect_at(7, K_REG, 3, 32'd13, "fwd x3 at retire");
    expect_at(0, K_REG, 1, 32'd5,  "fwd x1");
    expect_at(0, K_REG, 2, 32'd8,  "fwd x2");
    expect_perf(32'd0, 32'd0, "fwd");
    run_program(12, 1'b1);

    // Load-use: exactly one stall, so x2 retires at edge 7 instead of 6
    prep();
    dut.data_memory.memory[0] = 8'h05;
    put(0, enc_lw(1, 0, 12'd0));
    put(1, enc_r(7'h00, 1, 1, 3'b000, 2));
    expect_at(6, K_REG, 2, 32'd0,  "lu x2 before retire");
    expect_at(7, K_REG, 2, 32'd10, "lu x2 at retire");
    expect_at(0, K_REG, 1, 32'd5,  "lu x1");
    expect_perf(32'd1, 32'd0, "lu");
    run_program(12, 1'b1);

    // Taken and not-taken beq
    for (int t = 0; t < 2; t++) begin
      prep();
      put(0, addi(1, 0, 12'd1));
      put(3, (t == 0) ? enc_beq(1, 1, 13'd8) : enc_beq(1, 0, 13'd8));
      put(4, addi(5, 0, 12'd9));
      put(5, addi(6, 0, 12'd7));
      expect_at(0, K_REG, 5, (t == 0) ? 32'd0 : 32'd9, (t == 0) ? "br taken x5" : "br not-taken x5");
      expect_at(0, K_REG, 6, 32'd7, (t == 0) ? "br taken x6" : "br not-taken x6");
      expect_perf(32'd0, (t == 0) ? 32'd1 : 32'd0, (t == 0) ? "br taken" : "br not-taken");
      run_program(16, 1'b1);
    end

    // Memory: store-data forwarding, address wrap and alignment, x0 writes
    prep();
    put(0, addi(1, 0, 12'hFFE));
    put(1, enc_sw(12'd4, 1, 0));
    put(2, enc_lw(2, 0, 12'd4));
    put(3, addi(0, 0, 12'd5));
    put(4, addi(7, 0, 12'd1));
    put(5, addi(8, 0, 12'h123));
    put(6, enc_sw(12'd33, 8, 0));
    expect_at(0, K_DMEM, 4, 32'hFE, "mem dmem[4]");
    expect_at(0, K_DMEM, 5, 32'hFF, "mem dmem[5]");
    expect_at(0, K_DMEM, 6, 32'hFF, "mem dmem[6]");
    expect_at(0, K_DMEM, 7, 32'hFF, "mem dmem[7]");
    expect_at(0, K_REG, 2, 32'hFFFF_FFFE, "mem lw x2");
    expect_at(0, K_REG, 0, 32'd0, "mem x0 stays zero");
    expect_at(0, K_REG, 7, 32'd1, "mem x7 no fwd from x0");
    expect_at(0, K_DMEM, 0, 32'h23, "mem wrap dmem[0]");
    expect_at(0, K_DMEM, 1, 32'h01, "mem wrap dmem[1]");
    expect_at(0, K_DMEM, 3, 32'h00, "mem wrap dmem[3]");
    expect_perf(32'd0, 32'd0, "mem");
    run_program(16, 1'b1);

    // Arithmetic and wrap-around
    prep();
    put(0, addi(1, 0, 12'hFFF));
    put(1, enc_i(12'h404, 1, 3'b101, 2, 7'b0010011));
    put(2, enc_r(7'h01, 1, 1, 3'b000, 3));
    put(3, enc_r(7'h00, 1, 1, 3'b001, 4));
    put(4, addi(6, 0, 12'h0F0));
    put(5, enc_r(7'h00, 6, 1, 3'b100, 7));
    put(6, enc_r(7'h00, 6, 1, 3'b111, 8));
    put(7, enc_r(7'h00, 6, 0, 3'b110, 9));
    put(8, enc_r(7'h20, 1, 6, 3'b000, 5));
    expect_at(0, K_REG, 2, 32'hFFFF_FFFF, "alu srai");
    expect_at(0, K_REG, 3, 32'd1,         "alu mul wrap");
    expect_at(0, K_REG, 4, 32'h8000_0000, "alu sll");
    expect_at(0, K_REG, 7, 32'hFFFF_FF0F, "alu xor");
    expect_at(0, K_REG, 8, 32'h0000_00F0, "alu and");
    expect_at(0, K_REG, 9, 32'h0000_00F0, "alu or");
    expect_at(0, K_REG, 5, 32'h0000_00F1, "alu sub");
    expect_perf(32'd0, 32'd0, "alu");
    run_program(20, 1'b1);

    // Loop with a half-cycle reset pulse mid-run
    prep();
    dut.data_memory.memory[9] = 8'h5A;
    put(0, addi(1, 1, 12'd1));
    put(1, enc_beq(0, 0, 13'h1FFC));
    expect_at(0, K_REG, 1, 32'd6, "loop x1 before reset");
    run_program(20, 1'b1);
    @(negedge clk_i);
    #1 start_i = 1'b0;
    #1;
    check_val("midrst pc", dut.pc_q, 32'd0);
    check_val("midrst x1", dut.register.register[1], 32'd0);
    check_val("midrst ifid_instr", dut.ifid_instr_q, 32'd0);
    check_val("midrst dmem[9]", {24'd0, dut.data_memory.memory[9]}, 32'h5A);
    check_val("midrst imem[0]", dut.instruction_memory.memory[0], addi(1, 1, 12'd1));
`ifdef PERF_COUNTERS_EN
    check_val("midrst flush_count", flush_count_o, 32'd0);
`endif
    #2 start_i = 1'b1;
    expect_at(13, K_REG, 1, 32'd3, "restart x1 at 13");
    expect_at(14, K_REG, 1, 32'd4, "restart x1 at 14");
    run_program(14, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
